// File: rtl/m_div_seq.sv
// ---------------------------------------------------------------------------
// m_div_seq
//
// Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU
// instructions. One quotient bit is produced per cycle. Signed operations
// are handled by dividing magnitudes and fixing up signs at the end.
//
// Ports:
//   clk     in   core clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request; accepted only in IDLE when funct3[2] = 1
//   funct3  in   100 DIV, 101 DIVU, 110 REM, 111 REMU (sampled on accept)
//   rs1     in   dividend (sampled on accept)
//   rs2     in   divisor  (sampled on accept)
//   flush   in   synchronous abort; returns to IDLE, no done, result kept
//   busy    out  high from the cycle after an accepted start through DONE
//   done    out  one-cycle pulse, result valid in this cycle
//   result  out  quotient or remainder, held until the next result load
// ---------------------------------------------------------------------------
module m_div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // op[0] = unsigned, op[1] = remainder (funct3[1:0] of the accepted start)
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   cnt;
    logic            qneg;
    logic            rneg;

    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;

    // Operand decode used during SETUP, plus the shift/subtract step of CALC.
    // While in SETUP, dividend/divisor still hold the raw sampled operands;
    // from SETUP on, divisor holds the divisor magnitude.
    always_comb begin
        is_signed = ~op[0];
        is_rem    = op[1];
        a_neg     = is_signed & dividend[XLEN-1];
        b_neg     = is_signed & divisor[XLEN-1];
        a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
        overflow  = is_signed
                    && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (divisor == '1);
        // rem < divisor always holds, so the shifted value fits in XLEN+1 bits
        // and the borrow out of the subtract is the sign of the trial.
        rem_shift = {rem, quo[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. busy and done decode straight from the state
    // register, so nothing combinational from the inputs reaches them.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start && funct3[2]) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (div_zero || overflow) begin
                    state_next = DONE;
                end else begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = FIXUP;
                end
            end
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // An abort wins over everything, including a start in the same cycle.
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Datapath. A flush freezes every register (result in particular keeps
    // its previous value); the FSM alone carries the abort back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result   <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (start && funct3[2]) begin
                        op       <= funct3[1:0];
                        dividend <= rs1;
                        divisor  <= rs2;
                    end
                end
                SETUP: begin
                    qneg <= a_neg ^ b_neg;
                    rneg <= a_neg;
                    if (div_zero) begin
                        result <= is_rem ? dividend : '1;
                    end else if (overflow) begin
                        result <= is_rem ? '0 : dividend;
                    end else begin
                        rem     <= '0;
                        quo     <= a_mag;
                        divisor <= b_mag;
                        cnt     <= CW'(XLEN - 1);
                    end
                end
                CALC: begin
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                end
                FIXUP: begin
                    if (is_rem) begin
                        result <= rneg ? (~rem + 1'b1) : rem;
                    end else begin
                        result <= qneg ? (~quo + 1'b1) : quo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_div_seq.sv
// ---------------------------------------------------------------------------
// tb_m_div_seq
//
// Self-checking bench for m_div_seq. Expected results come from constants
// taken from the instruction semantics and from a plain-arithmetic reference
// model of RV32M division; expected latencies come from the cycle budget of
// the normal and special-case paths.
// ---------------------------------------------------------------------------
module tb_m_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;
    int cyc_count = 0;
    logic [31:0] last_exp = '0;

    m_div_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // 10 ns clock; inputs are driven and outputs sampled on the falling edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    // Reference model: RV32M results computed with 64-bit arithmetic, which
    // truncates toward zero and gives the remainder the dividend's sign.
    function automatic logic [31:0] model_result(input logic [2:0] f3,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            return f3[1] ? a : 32'hFFFF_FFFF;
        end
        if (!f3[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return f3[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_latency(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        if (b == 32'd0) return 2;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Issues one operation starting at the current falling edge (cycle 0)
    // and follows it to its done pulse. Optionally pulses a stray DIV start
    // in cycle inj_cyc. Returns on the falling edge of the cycle after DONE.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int inj_cyc,
                         output logic [31:0] res, output int lat,
                         output bit busy_ok, output int done_abs);
        busy_ok  = (busy === 1'b0);
        lat      = -1;
        res      = 'x;
        done_abs = -1;
        start    = 1'b1;
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == inj_cyc) begin
                start  = 1'b1;
                funct3 = 3'b100;
                rs1    = $urandom;
                rs2    = $urandom;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat      = c;
                res      = result;
                done_abs = cyc_count;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_busy: got %b, want 0", busy);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_done: got %b, want 0", done);
        end
        n_vec++;
        if (result !== 32'd0) begin
            n_err++;
            $display("[TB] FAIL reset_result: got %h, want 0", result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        last_exp = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s  [14] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b110, 3'b101,
                                  3'b100, 3'b110, 3'b101, 3'b111,
                                  3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as   [14] = '{32'd100, 32'd100, -32'sd100, -32'sd100, 32'd100,
                                  32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5, 32'd5,
                                  32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'h8000_0000};
        logic [31:0] bs   [14] = '{32'd7, 32'd7, 32'd7, 32'd7, -32'sd7, 32'd2,
                                  32'd0, 32'd0, 32'd0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF};
        logic [31:0] exps [14] = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
                                  32'd2, 32'h7FFF_FFFF,
                                  32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5,
                                  32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000};
        int          lats [14] = '{35, 35, 35, 35, 35, 35, 2, 2, 2, 2, 2, 2, 35, 35};
        logic [31:0] res;
        int          lat;
        bit          bok;
        int          dabs;
        for (int i = 0; i < 14; i++) begin
            do_op(f3s[i], as[i], bs[i], 0, res, lat, bok, dabs);
            n_vec++;
            if (res !== exps[i]) begin
                n_err++;
                $display("[TB] FAIL directed_result[%0d]: got %h, want %h", i, res, exps[i]);
            end
            n_vec++;
            if (lat !== lats[i]) begin
                n_err++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, lats[i]);
            end
            n_vec++;
            if (bok !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL directed_busy[%0d]: got %b, want 1", i, bok);
            end
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== exps[i]) begin
                n_err++;
                $display("[TB] FAIL directed_after[%0d]: got done=%b busy=%b result=%h, want 0 0 %h",
                         i, done, busy, result, exps[i]);
            end
            last_exp = exps[i];
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        int          exp_l;
        logic [31:0] res;
        int          lat;
        bit          bok;
        int          dabs;
        int          mode;
        logic [1:0]  sel;
        for (int i = 0; i < 40; i++) begin
            sel  = 2'($urandom_range(0, 3));
            f3   = {1'b1, sel};
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = 32'd0;
            if (mode == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (mode == 2) b = 32'($urandom_range(1, 20));
            if (mode == 3) b = -32'($urandom_range(1, 20));
            exp_r = model_result(f3, a, b);
            exp_l = model_latency(f3, a, b);
            do_op(f3, a, b, 0, res, lat, bok, dabs);
            n_vec++;
            if (res !== exp_r || lat !== exp_l || bok !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL random[%0d] f3=%b a=%h b=%h: got res=%h lat=%0d busy_ok=%b, want %h %0d 1",
                         i, f3, a, b, res, lat, bok, exp_r, exp_l);
            end
            last_exp = exp_r;
        end
    endtask

    task automatic test_start_in_calc();
        logic [31:0] res;
        int          lat;
        bit          bok;
        int          dabs;
        do_op(3'b100, 32'd100, 32'd7, 10, res, lat, bok, dabs);
        n_vec++;
        if (res !== 32'd14 || lat !== 35) begin
            n_err++;
            $display("[TB] FAIL start_in_calc: got res=%h lat=%0d, want 0000000e 35", res, lat);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL start_not_queued: got busy=%b, want 0", busy);
        end
        last_exp = 32'd14;
    endtask

    task automatic test_mul_ignored();
        bit ok = 1'b1;
        start  = 1'b1;
        funct3 = 3'b000;
        rs1    = 32'd6;
        rs2    = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (ok !== 1'b1 || result !== last_exp) begin
            n_err++;
            $display("[TB] FAIL mul_ignored: got ok=%b result=%h, want 1 %h", ok, result, last_exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        logic [31:0] r2;
        int          l1;
        int          l2;
        bit          b1;
        bit          b2;
        int          d1;
        int          d2;
        do_op(3'b101, 32'd1000, 32'd33, 0, r1, l1, b1, d1);
        do_op(3'b110, -32'sd1000, 32'd33, 0, r2, l2, b2, d2);
        n_vec++;
        if (r1 !== 32'd30 || r2 !== 32'hFFFF_FFF6) begin
            n_err++;
            $display("[TB] FAIL b2b_results: got %h %h, want 0000001e fffffff6", r1, r2);
        end
        n_vec++;
        if (d2 - d1 !== 36 || b2 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL b2b_spacing: got %0d busy_ok=%b, want 36 1", d2 - d1, b2);
        end
        last_exp = 32'hFFFF_FFF6;
    endtask

    task automatic test_flush();
        bit          done_seen = 1'b0;
        logic        busy_c11 = 1'b1;
        // flush and start together in IDLE: the start must be dropped
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b100;
        rs1    = 32'd50;
        rs2    = 32'd5;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL flush_beats_start: got busy=%b, want 0", busy);
        end
        // abort a running DIV in cycle 10
        start = 1'b1;
        rs1   = $urandom;
        rs2   = 32'd3;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 10);
            if (c == 11) busy_c11 = busy;
            if (done === 1'b1) done_seen = 1'b1;
        end
        flush = 1'b0;
        n_vec++;
        if (busy_c11 !== 1'b0 || done_seen !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL flush_abort: got busy@11=%b done_seen=%b, want 0 0", busy_c11, done_seen);
        end
        n_vec++;
        if (result !== last_exp) begin
            n_err++;
            $display("[TB] FAIL flush_result_kept: got %h, want %h", result, last_exp);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat;
        bit          bok;
        int          dabs;
        n_vec++;
        if (result !== last_exp) begin
            n_err++;
            $display("[TB] FAIL pre_reset_result: got %h, want %h", result, last_exp);
        end
        start  = 1'b1;
        funct3 = 3'b100;
        rs1    = 32'd77;
        rs2    = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_err++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b result=%h, want 0 0 0",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(3'b100, 32'd9, 32'd3, 0, res, lat, bok, dabs);
        n_vec++;
        if (res !== 32'd3 || lat !== 35) begin
            n_err++;
            $display("[TB] FAIL after_reset_div: got res=%h lat=%0d, want 00000003 35", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_in_calc();
        test_mul_ignored();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
